// File: rtl/sn_decoder.sv
// Stochastic-number decoder: counts ones over a BITSTREAM-bit frame delivered
// PAR bits per beat and converts the density into a clamped signed value.
module sn_decoder #(
  parameter int BITSTREAM = 64,
  parameter int PAR       = 8,
  parameter int QUANT     = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iClear,
  input  logic             iValid,
  output logic             oReady,
  input  logic [PAR-1:0]   iBits,
  input  logic             iLast,
  output logic             oValid,
  input  logic             iReady,
  output logic [QUANT-1:0] oData,
  output logic             oSat,
  output logic             oErr
);

  localparam int LOGB  = $clog2(BITSTREAM);
  localparam int SW    = LOGB + 1;
  localparam int BEATS = BITSTREAM / PAR;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RW    = SW + QUANT + 1;

  localparam logic signed [RW:0] QOFF = (RW+1)'(2 ** (QUANT - 1));
  localparam logic signed [RW:0] QMAX = (RW+1)'(2 ** (QUANT - 1) - 1);
  localparam logic signed [RW:0] QMIN = -QMAX;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t          state;
  logic [SW-1:0]   ones_sum;
  logic [CW-1:0]   beat_cnt;
  logic            err_acc;

  logic [SW-1:0]    beat_ones;
  logic [SW-1:0]    sum_next;
  logic             terminal;
  logic [RW-1:0]    scaled;
  logic signed [RW:0] q;
  logic             sat_hi;
  logic             sat_lo;
  logic [QUANT-1:0] data_next;

  function automatic logic [SW-1:0] popcount(input logic [PAR-1:0] v);
    logic [SW-1:0] c;
    c = '0;
    for (int i = 0; i < PAR; i++) c = c + SW'(v[i]);
    return c;
  endfunction

  // Rounded rescale of the ones count to QUANT bits, then re-centred around zero.
  always_comb begin
    beat_ones = popcount(iBits);
    sum_next  = ones_sum + beat_ones;
    terminal  = (beat_cnt == CW'(BEATS - 1));
    scaled    = ((RW'(sum_next) << QUANT) + RW'(BITSTREAM / 2)) >> LOGB;
    q         = $signed({1'b0, scaled}) - QOFF;
    sat_hi    = (q > QMAX);
    sat_lo    = (q < QMIN);
    if (sat_hi)      data_next = QMAX[QUANT-1:0];
    else if (sat_lo) data_next = QMIN[QUANT-1:0];
    else             data_next = q[QUANT-1:0];
  end

  assign oReady = (state == ACCUM);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state    <= ACCUM;
      ones_sum <= '0;
      beat_cnt <= '0;
      err_acc  <= 1'b0;
      oValid   <= 1'b0;
      oData    <= '0;
      oSat     <= 1'b0;
      oErr     <= 1'b0;
    end else if (iClear) begin
      state    <= ACCUM;
      ones_sum <= '0;
      beat_cnt <= '0;
      err_acc  <= 1'b0;
      oValid   <= 1'b0;
      oData    <= '0;
      oSat     <= 1'b0;
      oErr     <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (iValid) begin
            ones_sum <= sum_next;
            if (terminal) begin
              oData  <= data_next;
              oSat   <= sat_hi | sat_lo;
              oErr   <= err_acc | ~iLast;
              oValid <= 1'b1;
              state  <= HOLD;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
              err_acc  <= err_acc | iLast;
            end
          end
        end
        HOLD: begin
          // Result stays on the outputs after the handshake; only the accumulators restart.
          if (iReady) begin
            state    <= ACCUM;
            oValid   <= 1'b0;
            ones_sum <= '0;
            beat_cnt <= '0;
            err_acc  <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
